// File: rtl/diff_sched.sv
// Round-robin frame scheduler sharing one diff datapath between two RAM-read requesters.
// Beats reach o_x0_* two cycles after rd_en; a drain gap follows every frame before re-arbitration.
module diff_sched #(
  parameter int SAMPLE_WIDTH = 32,
  parameter int NUM          = 8,
  parameter int CNT_LEN      = 8,
  parameter int GAP          = 12
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_req0,
  input  logic                            i_mode0,
  input  logic [CNT_LEN-1:0]              i_len0,
  output logic                            o_gnt0,
  output logic                            o_rd0_en,
  input  logic [NUM*SAMPLE_WIDTH/2-1:0]   i_rd0_data,
  input  logic                            i_req1,
  input  logic                            i_mode1,
  input  logic [CNT_LEN-1:0]              i_len1,
  output logic                            o_gnt1,
  output logic                            o_rd1_en,
  input  logic [NUM*SAMPLE_WIDTH/2-1:0]   i_rd1_data,
  output logic                            o_switch,
  output logic [NUM*SAMPLE_WIDTH/2-1:0]   o_x0_data,
  output logic                            o_x0_valid,
  output logic                            o_x0_last,
  output logic                            o_owner,
  output logic                            o_busy,
  output logic                            o_frame_done
);

  localparam int DRAIN_LEN = GAP + 2;
  localparam int DCW       = $clog2(DRAIN_LEN);

  typedef enum logic [1:0] {IDLE, GRANT, STREAM, DRAIN} state_t;

  state_t             state, state_nxt;
  logic               prio;
  logic [CNT_LEN-1:0] len_q;
  logic [CNT_LEN-1:0] beat_cnt;
  logic [DCW-1:0]     drain_cnt;
  logic               pick;
  logic               rd_en;
  logic               rd_last;
  logic               drain_end;
  logic               p1_valid;
  logic               p1_last;

  // The datapath needs two beats to form a difference.
  function automatic logic [CNT_LEN-1:0] clamp_len(input logic [CNT_LEN-1:0] len);
    return (len < CNT_LEN'(2)) ? CNT_LEN'(2) : len;
  endfunction

  always_comb begin
    pick      = i_req1 & (~i_req0 | prio);
    rd_en     = (state == STREAM);
    rd_last   = rd_en && (beat_cnt == len_q - CNT_LEN'(1));
    drain_end = (state == DRAIN) && (drain_cnt == DCW'(DRAIN_LEN - 1));
    state_nxt = state;
    case (state)
      IDLE:    if (i_req0 || i_req1) state_nxt = GRANT;
      GRANT:   state_nxt = STREAM;
      STREAM:  if (rd_last) state_nxt = DRAIN;
      DRAIN:   if (drain_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign o_gnt0       = (state == GRANT) & ~o_owner;
  assign o_gnt1       = (state == GRANT) & o_owner;
  assign o_rd0_en     = rd_en & ~o_owner;
  assign o_rd1_en     = rd_en & o_owner;
  assign o_busy       = (state != IDLE);
  assign o_frame_done = drain_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      prio      <= 1'b0;
      o_owner   <= 1'b0;
      o_switch  <= 1'b0;
      len_q     <= '0;
      beat_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          // Grantee, mode and length are fixed here for the whole frame.
          if (i_req0 || i_req1) begin
            o_owner  <= pick;
            o_switch <= pick ? i_mode1 : i_mode0;
            len_q    <= clamp_len(pick ? i_len1 : i_len0);
          end
        end
        GRANT: begin
          prio     <= ~o_owner;
          beat_cnt <= '0;
        end
        STREAM: begin
          drain_cnt <= '0;
          if (!rd_last) beat_cnt <= beat_cnt + CNT_LEN'(1);
        end
        DRAIN: begin
          if (!drain_end) drain_cnt <= drain_cnt + DCW'(1);
        end
        default: ;
      endcase
    end
  end

  // Owner is stable for the whole frame and its drain, so it steers the capture mux.
  always_ff @(posedge clk) begin
    if (rst) begin
      p1_valid   <= 1'b0;
      p1_last    <= 1'b0;
      o_x0_valid <= 1'b0;
      o_x0_last  <= 1'b0;
      o_x0_data  <= '0;
    end else begin
      p1_valid   <= rd_en;
      p1_last    <= rd_last;
      o_x0_valid <= p1_valid;
      o_x0_last  <= p1_last;
      if (p1_valid) o_x0_data <= o_owner ? i_rd1_data : i_rd0_data;
    end
  end

endmodule
